// File: rtl/riscv_fetch_align.sv
// riscv_fetch_align
//   Instruction-fetch aligner that sits directly behind the PC register.
//   It issues word-aligned fetch requests and buffers the returned halfwords.
//   It extracts 16-bit (RVC) and 32-bit instructions at halfword-aligned PCs,
//   including a 32-bit instruction that straddles a word boundary, and hands
//   them to decode together with their PC.
//
//   Configuration macro: RISCV_ALIGN_RVC_EN
//     defined   : compressed instructions are supported. The buffer holds up
//                 to 3 halfwords, and a redirect to PC[1]=1 skips the low
//                 half of the first returned word.
//     undefined : every instruction is 32-bit and iscomp is tied 0. The
//                 buffer holds one word (2 halfwords), and redirect PC[1] is
//                 ignored.
//
// Handshake semantics:
//   Decode side: an instruction transfers on a cycle where both
//   o_riscv_align_valid and i_riscv_align_ready are high. While valid is high
//   and ready is low, instr/pc/iscomp hold steady. valid is never raised in a
//   flush cycle.
//   Memory side: a request transfers on a cycle where both
//   o_riscv_align_imemreq and i_riscv_align_imemready are high. The response
//   arrives as a single-cycle i_riscv_align_imemvalid pulse at least one cycle
//   later. At most one request is in flight at any time.
module riscv_fetch_align #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_riscv_align_clk,
  input  logic            i_riscv_align_rstn,
  input  logic            i_riscv_align_flush,
  input  logic [XLEN-1:0] i_riscv_align_flushpc,
  output logic            o_riscv_align_imemreq,
  output logic [XLEN-1:0] o_riscv_align_imemaddr,
  input  logic            i_riscv_align_imemready,
  input  logic            i_riscv_align_imemvalid,
  input  logic [31:0]     i_riscv_align_imemrdata,
  output logic            o_riscv_align_valid,
  input  logic            i_riscv_align_ready,
  output logic [31:0]     o_riscv_align_instr,
  output logic [XLEN-1:0] o_riscv_align_pc,
  output logic            o_riscv_align_iscomp,
  output logic            o_riscv_align_stallpc
);

  // The first fetch must be word aligned whatever RESET_PC says.
  localparam logic [XLEN-1:0] RST_PC = {RESET_PC[XLEN-1:2], 2'b00};

`ifdef RISCV_ALIGN_RVC_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif

  // Buffer and control state.
  logic [15:0]     hb [DEPTH];  // halfword buffer; hb[0] is the head
  logic [1:0]      cnt;         // number of valid halfwords in hb
  logic [XLEN-1:0] hpc;         // PC of hb[0]
  logic [XLEN-1:0] faddr;       // next fetch word address
  logic            os;          // a request is in flight
  logic            drp;         // in-flight response belongs to a stale stream
  logic            skl;         // next response: keep only the high halfword
  logic            st;          // first cycle after reset has passed

  // Decode of the head and the handshake terms.
  logic            head_comp;
  logic            head_ok;
  logic            fire;
  logic            req;
  logic            req_fire;
  logic            resp;

  // Next-state terms for the buffer.
  logic [1:0]      sh;
  logic [1:0]      cnt_s;
  logic [1:0]      app_n;
  logic [15:0]     app_lo;
  logic [15:0]     app_hi;
  logic [15:0]     b_s [DEPTH];
  logic [15:0]     b_n [DEPTH];
  logic [1:0]      cnt_n;
  logic [XLEN-1:0] hpc_step;

  // Redirect targets.
  logic [XLEN-1:0] flush_hpc;
  logic [XLEN-1:0] flush_faddr;
  logic            flush_skl;
  logic            unused_flushpc_bits;

  // Redirect target decode; the PC bits that do not matter are dropped here.
  always_comb begin
    flush_faddr = {i_riscv_align_flushpc[XLEN-1:2], 2'b00};
`ifdef RISCV_ALIGN_RVC_EN
    flush_hpc           = {i_riscv_align_flushpc[XLEN-1:1], 1'b0};
    flush_skl           = i_riscv_align_flushpc[1];
    unused_flushpc_bits = i_riscv_align_flushpc[0];
`else
    flush_hpc           = {i_riscv_align_flushpc[XLEN-1:2], 2'b00};
    flush_skl           = 1'b0;
    unused_flushpc_bits = ^i_riscv_align_flushpc[1:0];
`endif
  end

  // Classify the head halfword and decide whether a whole instruction is present.
  always_comb begin
`ifdef RISCV_ALIGN_RVC_EN
    head_comp = (hb[0][1:0] != 2'b11);
    head_ok   = head_comp ? (cnt >= 2'd1) : (cnt >= 2'd2);
`else
    head_comp = 1'b0;
    head_ok   = (cnt >= 2'd2);
`endif
  end

  // Decode-facing outputs. They depend only on buffer state, and flush masks valid.
  always_comb begin
    o_riscv_align_valid   = head_ok && !i_riscv_align_flush;
    o_riscv_align_instr   = '0;
    if (o_riscv_align_valid) begin
      o_riscv_align_instr = head_comp ? {16'h0000, hb[0]} : {hb[1], hb[0]};
    end
    o_riscv_align_pc      = hpc;
    o_riscv_align_iscomp  = o_riscv_align_valid && head_comp;
    fire                  = o_riscv_align_valid && i_riscv_align_ready;
    o_riscv_align_stallpc = !fire;
  end

  // Memory request: only ask when the buffer is guaranteed to have room for the word.
  always_comb begin
`ifdef RISCV_ALIGN_RVC_EN
    req = st && !os && (cnt <= 2'd1) && !i_riscv_align_flush;
`else
    req = st && !os && (cnt == 2'd0) && !i_riscv_align_flush;
`endif
    o_riscv_align_imemreq  = req;
    o_riscv_align_imemaddr = faddr;
    req_fire               = req && i_riscv_align_imemready;
    // A response counts only when we are waiting for one (stale pulses after reset are ignored).
    resp                   = i_riscv_align_imemvalid && os;
  end

  // Buffer update: shift out the consumed instruction first, then append behind what remains.
  always_comb begin
    sh       = fire ? (head_comp ? 2'd1 : 2'd2) : 2'd0;
    cnt_s    = cnt - sh;
    hpc_step = {{(XLEN-3){1'b0}}, sh, 1'b0};

    app_n  = 2'd0;
    app_lo = 16'h0000;
    app_hi = 16'h0000;
    if (resp && !drp) begin
      if (skl) begin
        app_n  = 2'd1;
        app_lo = i_riscv_align_imemrdata[31:16];
      end else begin
        app_n  = 2'd2;
        app_lo = i_riscv_align_imemrdata[15:0];
        app_hi = i_riscv_align_imemrdata[31:16];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      b_s[i] = 16'h0000;
      for (int j = 0; j < DEPTH; j++) begin
        if (j == i + int'(sh)) b_s[i] = hb[j];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      b_n[i] = b_s[i];
      if ((app_n != 2'd0) && (i == int'(cnt_s))) b_n[i] = app_lo;
      if ((app_n == 2'd2) && (i == int'(cnt_s) + 1)) b_n[i] = app_hi;
    end

    cnt_n = cnt_s + app_n;
  end

  // State registers. A flush overrides every other event in the same cycle.
  always_ff @(posedge i_riscv_align_clk or negedge i_riscv_align_rstn) begin
    if (!i_riscv_align_rstn) begin
      for (int i = 0; i < DEPTH; i++) hb[i] <= 16'h0000;
      cnt   <= 2'd0;
      hpc   <= RST_PC;
      faddr <= RST_PC;
      os    <= 1'b0;
      drp   <= 1'b0;
      skl   <= 1'b0;
      st    <= 1'b0;
    end else begin
      st <= 1'b1;
      if (i_riscv_align_flush) begin
        cnt   <= 2'd0;
        hpc   <= flush_hpc;
        faddr <= flush_faddr;
        skl   <= flush_skl;
        // A response still owed to the old stream must be thrown away when it shows up.
        // A response arriving right now is dropped on the floor.
        os    <= os && !i_riscv_align_imemvalid;
        drp   <= os && !i_riscv_align_imemvalid;
      end else begin
        hb  <= b_n;
        cnt <= cnt_n;
        hpc <= hpc + hpc_step;
        if (resp) begin
          os  <= 1'b0;
          drp <= 1'b0;
          // skl is kept across a dropped word; it applies to the first word of the new stream.
          if (!drp) skl <= 1'b0;
        end else if (req_fire) begin
          os    <= 1'b1;
          faddr <= faddr + {{(XLEN-3){1'b0}}, 3'd4};
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_fetch_align.sv
// tb_riscv_fetch_align
//   Directed bench for riscv_fetch_align with hand-computed expected values.
//   The common sequence holds in both builds. The RISCV_ALIGN_RVC_EN build
//   adds compressed-instruction cases; the default build adds the
//   32-bit-only cases.
module tb_riscv_fetch_align;

  localparam int XLEN = 64;

  logic            clk;
  logic            rstn;
  logic            flush;
  logic [XLEN-1:0] flushpc;
  logic            imemreq;
  logic [XLEN-1:0] imemaddr;
  logic            imemready;
  logic            imemvalid;
  logic [31:0]     imemrdata;
  logic            valid;
  logic            ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            iscomp;
  logic            stallpc;

  int total = 0;
  int bad   = 0;

  riscv_fetch_align #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
    .i_riscv_align_clk       (clk),
    .i_riscv_align_rstn      (rstn),
    .i_riscv_align_flush     (flush),
    .i_riscv_align_flushpc   (flushpc),
    .o_riscv_align_imemreq   (imemreq),
    .o_riscv_align_imemaddr  (imemaddr),
    .i_riscv_align_imemready (imemready),
    .i_riscv_align_imemvalid (imemvalid),
    .i_riscv_align_imemrdata (imemrdata),
    .o_riscv_align_valid     (valid),
    .i_riscv_align_ready     (ready),
    .o_riscv_align_instr     (instr),
    .o_riscv_align_pc        (pc),
    .o_riscv_align_iscomp    (iscomp),
    .o_riscv_align_stallpc   (stallpc)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check: one comparison, counted, reported on mismatch.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Move from one falling edge to the next.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) for a fetch request, check its address, and let it be accepted.
  task automatic wait_req(input logic [63:0] a, input string tag);
    int n;
    n = 0;
    #1;
    while (!imemreq && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk({tag, "_req"}, {63'd0, imemreq}, 64'd1);
    chk({tag, "_addr"}, imemaddr, a);
    cyc();
  endtask

  // Return one response word as a single-cycle pulse.
  task automatic respond(input logic [31:0] d);
    imemvalid = 1'b1;
    imemrdata = d;
    cyc();
    imemvalid = 1'b0;
    imemrdata = 32'h0;
  endtask

  // Expect an instruction at the head, then consume it.
  task automatic take(input logic [31:0] ei, input logic [63:0] ep, input logic ec, input string tag);
    ready = 1'b1;
    #1;
    chk({tag, "_valid"},  {63'd0, valid},   64'd1);
    chk({tag, "_instr"},  {32'd0, instr},   {32'd0, ei});
    chk({tag, "_pc"},     pc,               ep);
    chk({tag, "_iscomp"}, {63'd0, iscomp},  {63'd0, ec});
    chk({tag, "_stall"},  {63'd0, stallpc}, 64'd0);
    cyc();
  endtask

  // Driver sequence.
  initial begin
    rstn      = 1'b0;
    flush     = 1'b0;
    flushpc   = '0;
    imemready = 1'b1;
    imemvalid = 1'b0;
    imemrdata = 32'h0;
    ready     = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",    {63'd0, imemreq}, 64'd0);
    chk("rst_valid",  {63'd0, valid},   64'd0);
    chk("rst_stall",  {63'd0, stallpc}, 64'd1);
    chk("rst_instr",  {32'd0, instr},   64'd0);
    chk("rst_pc",     pc,               64'd0);
    chk("rst_iscomp", {63'd0, iscomp},  64'd0);
    rstn = 1'b1;

    // First request one cycle after release.
    cyc();
    #1;
    chk("rel_req",  {63'd0, imemreq}, 64'd1);
    chk("rel_addr", imemaddr,         64'h0);
    cyc();
    #1;
    chk("os_block", {63'd0, imemreq}, 64'd0);
    respond(32'h0000_0013);
    #1;
    chk("full_block", {63'd0, imemreq}, 64'd0);
    take(32'h0000_0013, 64'h0, 1'b0, "first");

    // Backpressure: the head must hold and no new request may go out.
    wait_req(64'h4, "bp");
    ready = 1'b0;
    respond(32'h0000_0517);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", {63'd0, valid},   64'd1);
      chk("bp_instr", {32'd0, instr},   64'h517);
      chk("bp_pc",    pc,               64'h4);
      chk("bp_stall", {63'd0, stallpc}, 64'd1);
      chk("bp_noreq", {63'd0, imemreq}, 64'd0);
      cyc();
    end
    take(32'h0000_0517, 64'h4, 1'b0, "bp_rel");

    // Flush while an instruction is presented: no handshake, buffer emptied.
    wait_req(64'h8, "f1");
    respond(32'h0000_0293);
    #1;
    chk("f1_pre_valid", {63'd0, valid}, 64'd1);
    flush   = 1'b1;
    flushpc = 64'h2000;
    #1;
    chk("f1_valid", {63'd0, valid},   64'd0);
    chk("f1_stall", {63'd0, stallpc}, 64'd1);
    chk("f1_noreq", {63'd0, imemreq}, 64'd0);
    cyc();
    flush = 1'b0;
    wait_req(64'h2000, "f1_tgt");
    respond(32'h00C0_0313);
    take(32'h00C0_0313, 64'h2000, 1'b0, "f1_new");

    // Flush in the same cycle as a response: the word is dropped, nothing left owed.
    wait_req(64'h2004, "f2");
    flush     = 1'b1;
    flushpc   = 64'h3000;
    imemvalid = 1'b1;
    imemrdata = 32'h1111_1111;
    cyc();
    flush     = 1'b0;
    imemvalid = 1'b0;
    imemrdata = 32'h0;
    #1;
    chk("f2_valid", {63'd0, valid},   64'd0);
    chk("f2_req",   {63'd0, imemreq}, 64'd1);
    wait_req(64'h3000, "f2_tgt");
    respond(32'h0010_0393);
    take(32'h0010_0393, 64'h3000, 1'b0, "f2_new");

`ifdef RISCV_ALIGN_RVC_EN
    // Two compressed instructions from one word.
    wait_req(64'h3004, "pair");
    respond(32'h4501_4501);
    take(32'h0000_4501, 64'h3004, 1'b1, "pair0");
    take(32'h0000_4501, 64'h3006, 1'b1, "pair1");

    // A 32-bit instruction straddling a word boundary.
    wait_req(64'h3008, "strd");
    respond(32'h0513_4501);
    take(32'h0000_4501, 64'h3008, 1'b1, "strd_c0");
    #1;
    chk("strd_wait_valid", {63'd0, valid},   64'd0);
    chk("strd_wait_stall", {63'd0, stallpc}, 64'd1);
    wait_req(64'h300C, "strd_w1");
    respond(32'h4501_0000);
    take(32'h0000_0513, 64'h300A, 1'b0, "strd_i32");
    take(32'h0000_4501, 64'h300E, 1'b1, "strd_c1");

    // Flush to a halfword target while a fetch is in flight.
    wait_req(64'h3010, "fo");
    flush   = 1'b1;
    flushpc = 64'h1002;
    #1;
    chk("fo_valid", {63'd0, valid},   64'd0);
    chk("fo_noreq", {63'd0, imemreq}, 64'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fo_wait", {63'd0, imemreq}, 64'd0);
    respond(32'hDEAD_BEEF);
    #1;
    chk("fo_dropped", {63'd0, valid}, 64'd0);
    wait_req(64'h1000, "fo_tgt");
    respond(32'h0001_ABCD);
    take(32'h0000_0001, 64'h1002, 1'b1, "fo_new");
`else
    // One word is one 32-bit instruction, even if the low bits look compressed.
    wait_req(64'h3004, "w32");
    respond(32'h4501_4501);
    take(32'h4501_4501, 64'h3004, 1'b0, "w32");
    #1;
    chk("w32_single", {63'd0, valid}, 64'd0);

    // Flush to a halfword target while a fetch is in flight: PC bit 1 is dropped.
    wait_req(64'h3008, "fo");
    flush   = 1'b1;
    flushpc = 64'h1002;
    #1;
    chk("fo_valid", {63'd0, valid},   64'd0);
    chk("fo_noreq", {63'd0, imemreq}, 64'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fo_wait", {63'd0, imemreq}, 64'd0);
    respond(32'hDEAD_BEEF);
    #1;
    chk("fo_dropped", {63'd0, valid}, 64'd0);
    wait_req(64'h1000, "fo_tgt");
    respond(32'h00A0_0093);
    take(32'h00A0_0093, 64'h1000, 1'b0, "fo_new");
`endif

    // Reset with a fetch in flight; the late response must be ignored.
    wait_req(64'h1004, "mrst");
    rstn = 1'b0;
    #1;
    chk("mrst_req",   {63'd0, imemreq}, 64'd0);
    chk("mrst_valid", {63'd0, valid},   64'd0);
    chk("mrst_pc",    pc,               64'h0);
    cyc();
    rstn      = 1'b1;
    imemvalid = 1'b1;
    imemrdata = 32'h0000_0393;
    cyc();
    imemvalid = 1'b0;
    imemrdata = 32'h0;
    #1;
    chk("mrst_stale", {63'd0, valid},   64'd0);
    chk("mrst_req1",  {63'd0, imemreq}, 64'd1);
    wait_req(64'h0, "mrst_re");
    respond(32'h0000_0013);
    take(32'h0000_0013, 64'h0, 1'b0, "mrst_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_align.md
Name: riscv_fetch_align

Overview:
- Instruction-fetch aligner directly downstream of the PC register.
- Issues word-aligned fetch requests to instruction memory and buffers the returned halfwords.
- Extracts 16-bit (RVC) and 32-bit instructions at halfword-aligned PCs, including 32-bit instructions that straddle a word boundary.
- Presents each instruction with its PC to decode over a valid/ready handshake, and drives the PC register's stall input.

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h0, first fetch address after reset; bits [1:0] forced 0.

Ports:
- i_riscv_align_clk  in  1  clock, rising edge.
- i_riscv_align_rstn  in  1  reset: asynchronous assert, active-low.
- i_riscv_align_flush  in  1  redirect: discard all buffered/in-flight state.
- i_riscv_align_flushpc  in  XLEN  redirect target; bit 0 ignored.
- o_riscv_align_imemreq  out  1  fetch request.
- o_riscv_align_imemaddr  out  XLEN  fetch word address, bits [1:0]=0.
- i_riscv_align_imemready  in  1  request accepted when req&&ready.
- i_riscv_align_imemvalid  in  1  response valid, 1 cycle pulse.
- i_riscv_align_imemrdata  in  32  response word, little-endian halfwords.
- o_riscv_align_valid  out  1  instruction available.
- i_riscv_align_ready  in  1  decode accepts.
- o_riscv_align_instr  out  32  instruction; RVC in [15:0], [31:16]=0.
- o_riscv_align_pc  out  XLEN  PC of o_riscv_align_instr.
- o_riscv_align_iscomp  out  1  1 = 16-bit instruction.
- o_riscv_align_stallpc  out  1  = !(valid&&ready); drives the PC register stall input.

Behaviour:
- State: 3-halfword buffer hb[0..2], count cnt (0..3), head PC hpc, fetch address faddr, outstanding flag os, drop flag drp, skip-low flag skl, started flag st.
- Reset (rstn low): cnt=0, os=drp=st=0, hpc=faddr=RESET_PC, skl=0.
  - Output reset values: valid=0, imemreq=0, instr=0, pc=RESET_PC, iscomp=0, stallpc=1.
  - st sets on the first clock after rstn releases.
- Request:
  - imemreq = st && !os && cnt<=1 && !flush; imemaddr=faddr.
  - On req&&ready: os=1, faddr+=4.
  - Only one request is outstanding at a time; response latency is at least 1 cycle.
- Response (imemvalid):
  - os=0.
  - If drp: discard the word and clear drp.
  - Else if skl: append only [31:16] (cnt+1) and clear skl.
  - Else: append [15:0] then [31:16] (cnt+2).
- Extract from head hb[0]:
  - If hb[0][1:0]!=2'b11 and cnt>=1: valid, iscomp=1.
  - If hb[0][1:0]==2'b11 and cnt>=2: valid, instr={hb[1],hb[0]}, iscomp=0.
  - pc=hpc. Outputs are combinational from buffer state.
- Consume (valid&&ready):
  - Shift by 1 (RVC) or 2 halfwords; hpc+=2 or +4 (XLEN wrap).
  - A consume and an append in the same cycle: shift first, then append behind the remaining entries. cnt never exceeds 3.
- Hold: while valid&&!ready, instr/pc/iscomp stay stable.
- Flush has priority over all other events in the same cycle:
  - valid forced 0 in the flush cycle, so no handshake occurs.
  - cnt=0; hpc={flushpc[XLEN-1:1],1'b0}; faddr={flushpc[XLEN-1:2],2'b00}; skl=flushpc[1].
  - drp=1 if os=1 and no response arrives in the same cycle; a response arriving in the flush cycle is discarded.
- Reset mid-operation returns all state to its reset value immediately; any in-flight response after reset is ignored (os=0).

Optional Feature:
- Macro: RISCV_ALIGN_RVC_EN.
- With the macro: behaviour as above.
- Without the macro:
  - Every instruction is 32-bit and iscomp is tied 0.
  - flushpc bit 1 is ignored and skl is never set.
  - The head is always the low half of a word; buffer depth is 2 halfwords.
  - Request condition becomes cnt==0.

Test Plan:
- Reset, RESET_PC=0, rstn low 3 cycles: imemreq=0 and valid=0 during reset; 1 cycle after release imemreq=1, addr=0x0. Response 0x00000013 -> valid, instr=0x00000013, pc=0x0, iscomp=0, stallpc=0 with ready=1.
- RVC pair: response 0x45014501 at 0x0 -> instr=0x00004501 at pc 0x0, then at pc 0x2, both iscomp=1.
- Straddle: word0=0x05134501, word1=0x45010000.
  - Outputs: 0x00004501 @0x0, then 0x00000513 @0x2 only after word1 arrives (stallpc=1 while waiting), then 0x00004501 @0x6.
- Flush to 0x1002 while a request to 0x4 is outstanding:
  - The 0x4 response is discarded.
  - Next request addr=0x1000; response 0x0001ABCD -> instr=0x00000001, pc=0x1002, iscomp=1.
- Backpressure: ready=0 for 5 cycles with valid=1 -> instr/pc stable, stallpc=1, cnt<=3, no request issued once cnt>=2. Release ready -> all instructions emitted in order, no loss or duplication.
- Without RISCV_ALIGN_RVC_EN: response 0x45014501 -> one instruction 0x45014501, pc=0x0, iscomp=0; flush to 0x1002 -> pc=0x1000.
